// File: rtl/attr_palette_pkg.sv
// -----------------------------------------------------------------------------
// attr_palette_pkg
//
// Shared definitions for the text-mode attribute palette controller:
//   - RGB_W / IDX_W        : colour word width and palette index width
//   - ATTR_W               : width of a text attribute byte
//   - PAL_DEPTH            : number of palette entries
//   - cpu_state_t          : states of the CPU palette-access FSM
//   - DEFAULT_PALETTE      : standard 16-colour VGA palette loaded on reset
//   - pal_select()         : attribute/glyph/blink -> palette index
// -----------------------------------------------------------------------------
package attr_palette_pkg;

    localparam int RGB_W     = 24;
    localparam int IDX_W     = 4;
    localparam int ATTR_W    = 8;
    localparam int PAL_DEPTH = 16;

    typedef enum logic {
        CPU_IDLE = 1'b0,
        CPU_ACK  = 1'b1
    } cpu_state_t;

    localparam logic [RGB_W-1:0] DEFAULT_PALETTE [PAL_DEPTH] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };

    // Picks the palette entry for one character-cell pixel.
    // In blink mode attr[7] is the blink flag, so the background is limited
    // to the low eight colours; a blinking cell in the hidden phase shows
    // only its background.
    function automatic logic [IDX_W-1:0] pal_select(
        input logic [ATTR_W-1:0] attr,
        input logic              glyph,
        input logic              blink_mode,
        input logic              phase
    );
        logic eff_glyph;
        eff_glyph = glyph & ~(blink_mode & attr[7] & phase);
        if (eff_glyph) begin
            return attr[3:0];
        end else if (blink_mode) begin
            return {1'b0, attr[6:4]};
        end else begin
            return attr[7:4];
        end
    endfunction

endpackage

// File: rtl/attr_palette_blink_timer.sv
// -----------------------------------------------------------------------------
// blink_timer
//
// Counts frame-start strobes and toggles the blink phase every BLINK_FRAMES
// frames.
//
// Parameters:
//   BLINK_FRAMES : frames per blink half-period, 1..255
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   vsync_pulse  in   one-cycle frame-start strobe
//   blink_phase  out  1 = blinking cells currently hidden
// -----------------------------------------------------------------------------
module blink_timer #(
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_pulse,
    output logic blink_phase
);

    // Terminal count; with BLINK_FRAMES = 1 this is zero, so the counter
    // never leaves zero and the phase flips on every strobe.
    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    logic [7:0] frame_cnt_reg;
    logic [7:0] frame_cnt_next;
    logic       phase_reg;
    logic       phase_next;

    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        phase_next     = phase_reg;
        if (vsync_pulse) begin
            if (frame_cnt_reg == LAST_FRAME) begin
                frame_cnt_next = 8'd0;
                phase_next     = ~phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_reg <= 8'd0;
            phase_reg     <= 1'b0;
        end else begin
            frame_cnt_reg <= frame_cnt_next;
            phase_reg     <= phase_next;
        end
    end

    assign blink_phase = phase_reg;

endmodule

// File: rtl/attr_palette_ctrl.sv
// -----------------------------------------------------------------------------
// attr_palette_ctrl
//
// Text-mode colour stage: turns an attribute byte plus a font bit into a
// 24-bit RGB pixel through a 16-entry palette shared with a CPU port.
//
// Parameters:
//   BLINK_FRAMES : frames per blink half-period, 1..255
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   pix_valid            pixel lookup request this cycle
//   pix_attr[7:0]        text attribute byte
//   pix_glyph            font bit, 1 = foreground
//   pix_blank            blanking interval (output forced black)
//   vsync_pulse          one-cycle frame-start strobe
//   blink_en             1 = attr[7] is blink, 0 = attr[7] is bright bg
//   rgb_out[23:0]        pixel colour, two cycles after the request
//   rgb_valid            pix_valid delayed two cycles
//   blink_phase          current blink phase
//   cpu_req/we/idx/wdata CPU palette access, held until cpu_ack
//   cpu_ack              one-cycle completion strobe
//   cpu_rdata[23:0]      read data, held until the next read
// -----------------------------------------------------------------------------
module attr_palette_ctrl
    import attr_palette_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_valid,
    input  logic [ATTR_W-1:0]   pix_attr,
    input  logic                pix_glyph,
    input  logic                pix_blank,
    input  logic                vsync_pulse,
    input  logic                blink_en,
    output logic [RGB_W-1:0]    rgb_out,
    output logic                rgb_valid,
    output logic                blink_phase,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [IDX_W-1:0]    cpu_idx,
    input  logic [RGB_W-1:0]    cpu_wdata,
    output logic                cpu_ack,
    output logic [RGB_W-1:0]    cpu_rdata
);

    // -------------------------------------------------------------------------
    // Blink timing
    // -------------------------------------------------------------------------
    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync_pulse (vsync_pulse),
        .blink_phase (blink_phase)
    );

    // -------------------------------------------------------------------------
    // Palette port arbitration
    // -------------------------------------------------------------------------
    // The palette has one access per cycle. A visible pixel always owns it;
    // the CPU only gets the port in cycles the pixel path leaves free.
    logic             pix_use;
    logic [IDX_W-1:0] pix_idx;
    logic [IDX_W-1:0] access_idx;
    logic [RGB_W-1:0] rd_word;
    logic             cpu_grant;
    logic             pal_wr;
    cpu_state_t       state_reg;

    assign pix_use    = pix_valid & ~pix_blank;
    // blink_phase is the registered value, so a pixel sampled together with
    // a toggling vsync strobe still sees the phase from before the toggle.
    assign pix_idx    = pal_select(pix_attr, pix_glyph, blink_en, blink_phase);
    assign access_idx = pix_use ? pix_idx : cpu_idx;
    assign cpu_grant  = (state_reg == CPU_IDLE) & cpu_req & ~pix_use;
    assign pal_wr     = cpu_grant & cpu_we;

    // -------------------------------------------------------------------------
    // Palette storage
    // -------------------------------------------------------------------------
    // Kept in flops rather than block RAM because every entry must return
    // to its default colour on reset.
    logic [PAL_DEPTH-1:0][RGB_W-1:0] palette_word;

    generate
        for (genvar gi = 0; gi < PAL_DEPTH; gi++) begin : g_entry
            logic [RGB_W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    entry_reg <= DEFAULT_PALETTE[gi];
                end else if (pal_wr && (cpu_idx == IDX_W'(gi))) begin
                    entry_reg <= cpu_wdata;
                end
            end

            assign palette_word[gi] = entry_reg;
        end
    endgenerate

    // A write lands at the grant edge, so a pixel sampled at that same edge
    // still reads the old word and any later pixel reads the new one.
    assign rd_word = palette_word[access_idx];

    // -------------------------------------------------------------------------
    // CPU access FSM
    // -------------------------------------------------------------------------
    logic             cpu_ack_reg;
    logic [RGB_W-1:0] cpu_rdata_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= CPU_IDLE;
            cpu_ack_reg   <= 1'b0;
            cpu_rdata_reg <= '0;
        end else begin
            case (state_reg)
                CPU_IDLE: begin
                    cpu_ack_reg <= 1'b0;
                    if (cpu_grant) begin
                        state_reg   <= CPU_ACK;
                        cpu_ack_reg <= 1'b1;
                        if (!cpu_we) begin
                            cpu_rdata_reg <= rd_word;
                        end
                    end
                end
                CPU_ACK: begin
                    // The request is still asserted here; it is ignored
                    // so that one request yields exactly one access.
                    state_reg   <= CPU_IDLE;
                    cpu_ack_reg <= 1'b0;
                end
                default: begin
                    state_reg   <= CPU_IDLE;
                    cpu_ack_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_reg;
    assign cpu_rdata = cpu_rdata_reg;

    // -------------------------------------------------------------------------
    // Pixel pipeline: palette read register, then output register
    // -------------------------------------------------------------------------
    logic             s1_valid_reg;
    logic             s1_show_reg;
    logic [RGB_W-1:0] s1_rgb_reg;
    logic             rgb_valid_reg;
    logic [RGB_W-1:0] rgb_out_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_show_reg   <= 1'b0;
            s1_rgb_reg    <= '0;
            rgb_valid_reg <= 1'b0;
            rgb_out_reg   <= '0;
        end else begin
            s1_valid_reg  <= pix_valid;
            s1_show_reg   <= pix_use;
            s1_rgb_reg    <= pix_use ? rd_word : '0;
            rgb_valid_reg <= s1_valid_reg;
            // Blanked and idle slots both drive black.
            rgb_out_reg   <= s1_show_reg ? s1_rgb_reg : '0;
        end
    end

    assign rgb_valid = rgb_valid_reg;
    assign rgb_out   = rgb_out_reg;

endmodule

// File: doc/attr_palette_ctrl.md
ATTR_PALETTE_CTRL -- requirements
Module: attr_palette_ctrl

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 16: frames per blink half-period (legal range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port pix_valid  in  1  pixel lookup request this cycle.
REQ-005 SHALL have port pix_attr  in  8  text attribute byte.
REQ-006 SHALL have port pix_glyph  in  1  font bit; 1 = foreground.
REQ-007 SHALL have port pix_blank  in  1  display blanking interval.
REQ-008 SHALL have port vsync_pulse  in  1  one-cycle frame-start strobe.
REQ-009 SHALL have port blink_en  in  1  1 = attr[7] means blink; 0 = attr[7] means bright background.
REQ-010 SHALL have port rgb_out  out  24  pixel colour, 8:8:8.
REQ-011 SHALL have port rgb_valid  out  1  rgb_out qualifier.
REQ-012 SHALL have port blink_phase  out  1  current blink phase; 1 = blinking cells hidden.
REQ-013 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_idx in 4, cpu_wdata in 24: palette access request.
REQ-014 SHALL have ports cpu_ack out 1, cpu_rdata out 24: access completion and read data.

Function
REQ-015 SHALL hold a 16-entry x 24-bit palette, single access per cycle, shared between pixel path and CPU.
REQ-016 Pixel path SHALL have priority: the palette is used by the pixel path in any cycle with pix_valid=1 and pix_blank=0.
REQ-017 Pixel inputs sampled at edge N SHALL produce rgb_out/rgb_valid at edge N+2 (fixed 2-cycle latency); rgb_valid = pix_valid delayed 2.
REQ-018 fg index = attr[3:0]; bg index = blink_en ? {1'b0, attr[6:4]} : attr[7:4].
REQ-019 Effective glyph = pix_glyph AND NOT (blink_en AND attr[7] AND blink_phase).
REQ-020 rgb_out = palette[effective glyph ? fg : bg]; if the pixel was sampled with pix_blank=1, rgb_out = 24'h000000 with rgb_valid still following pix_valid.
REQ-021 rgb_out SHALL be 24'h000000 whenever rgb_valid=0.
REQ-022 CPU FSM states IDLE, ACK; IDLE->ACK when cpu_req=1 and palette not used by pixel path that cycle; ACK->IDLE unconditionally.
REQ-023 Grant edge SHALL perform the access: write palette[cpu_idx]=cpu_wdata if cpu_we, else capture palette[cpu_idx] into cpu_rdata.
REQ-024 cpu_ack SHALL be high exactly the one cycle in ACK; cpu_rdata valid in that cycle, holds until next read; cpu_req ignored while in ACK.
REQ-025 Requester SHALL hold cpu_req, cpu_we, cpu_idx, cpu_wdata stable until cpu_ack; no timeout, CPU waits indefinitely while pixel path is busy.
REQ-026 A palette write granted at edge N SHALL be visible to pixels sampled at edge N+1 or later; pixels sampled at or before edge N use the old value.
REQ-027 Frame counter (8 bit) SHALL increment on each vsync_pulse; on reaching BLINK_FRAMES-1 with vsync_pulse it SHALL wrap to 0 and toggle blink_phase.
REQ-028 A pixel sampled in the same cycle as a toggling vsync_pulse SHALL use the pre-toggle blink_phase.
REQ-029 BLINK_FRAMES=1 SHALL toggle blink_phase on every vsync_pulse.

Reset
REQ-030 With rst_n=0 at an edge: palette = standard VGA 16-colour defaults, FSM = IDLE, cpu_ack=0, cpu_rdata=0, rgb_valid=0, rgb_out=0, blink_phase=0, frame counter=0.
REQ-031 Reset mid-transaction SHALL abandon the access without ack; a write not yet granted SHALL NOT take effect; in-flight pixels are discarded.

Structure
REQ-032 Package attr_palette_pkg SHALL hold RGB width (24), index width (4), CPU FSM state enum, and the 16-entry default palette constant (0:000000 1:0000AA 2:00AA00 3:00AAAA 4:AA0000 5:AA00AA 6:AA5500 7:AAAAAA 8:555555 9:5555FF A:55FF55 B:55FFFF C:FF5555 D:FF55FF E:FFFF55 F:FFFFFF).
REQ-033 Frame counter and blink_phase SHALL be a sub-module blink_timer(clk, rst_n, vsync_pulse, blink_phase).

Verification
REQ-034 After reset, pix_valid=1, attr=8'h1E, glyph=1 -> rgb_out=FFFF55, rgb_valid=1 two cycles later; glyph=0 -> 0000AA.
REQ-035 blink_en=1, attr=8'h8F, glyph=1, BLINK_FRAMES=2: 2 vsync pulses -> blink_phase=1, rgb_out=000000 (bg); 2 more -> FFFFFF.
REQ-036 blink_en=0, attr=8'hC0, glyph=0 -> rgb_out=FF5555.
REQ-037 cpu_req write idx 4=123456 while pix_valid=1, pix_blank=0 for 10 cycles -> no cpu_ack until pix_valid drops; ack one cycle after grant; next attr=8'h04 glyph=1 -> 123456.
REQ-038 cpu read idx 9 with pix_blank=1 -> cpu_ack one cycle later, cpu_rdata=5555FF; rst_n=0 during ACK -> cpu_ack=0 next cycle, palette idx 4 restored to AA0000.
